// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: op codes, FSM states and op classification.
// Optional iterative MUL/DIVU/REMU support is enabled with ALU_SEQ_MULDIV_EN.
package alu_seq_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_XOR  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIVU = 4'd11;
    localparam logic [3:0] ALU_REMU = 4'd12;

`ifdef ALU_SEQ_MULDIV_EN
    typedef enum logic [1:0] {
        ALU_ST_IDLE = 2'd0,
        ALU_ST_BUSY = 2'd1,
        ALU_ST_DONE = 2'd2
    } alu_state_t;
`else
    // Without the iterative unit there is nothing to wait for between accept and result.
    typedef enum logic [0:0] {
        ALU_ST_IDLE = 1'b0,
        ALU_ST_DONE = 1'b1
    } alu_state_t;
`endif

    // True for the ops handled by the multi-cycle shift-add / restoring-divide unit.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative multiply / unsigned divide datapath: one bit per cycle, WIDTH iterations.
// MUL is shift-add (low WIDTH bits kept); DIVU/REMU use restoring division.
// A zero divisor naturally yields quotient = all ones and remainder = dividend.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int            CW         = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

    // acc_reg: product accumulator (MUL) or partial remainder (DIVU/REMU).
    // sh_a_reg: multiplicand shifting left (MUL) or dividend turning into quotient.
    // sh_b_reg: multiplier shifting right (MUL) or fixed divisor.
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] sh_a_reg;
    logic [WIDTH-1:0] sh_b_reg;
    logic [CW-1:0]    count_reg;
    logic             run_reg;
    logic             is_mul_reg;
    logic             is_rem_reg;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;

    // Restoring-divide step: bring in next dividend bit, try subtracting the divisor.
    always_comb begin
        div_shift = {acc_reg, sh_a_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, sh_b_reg};
    end

    // Load operands on start, then iterate once per cycle until the counter drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg    <= '0;
            sh_a_reg   <= '0;
            sh_b_reg   <= '0;
            count_reg  <= '0;
            run_reg    <= 1'b0;
            is_mul_reg <= 1'b0;
            is_rem_reg <= 1'b0;
        end else if (start) begin
            acc_reg    <= '0;
            sh_a_reg   <= a;
            sh_b_reg   <= b;
            count_reg  <= COUNT_INIT;
            run_reg    <= 1'b1;
            is_mul_reg <= (op_sel == ALU_MUL);
            is_rem_reg <= (op_sel == ALU_REMU);
        end else if (run_reg) begin
            if (count_reg != '0) begin
                count_reg <= count_reg - CW'(1);
                if (is_mul_reg) begin
                    if (sh_b_reg[0]) begin
                        acc_reg <= acc_reg + sh_a_reg;
                    end
                    sh_a_reg <= sh_a_reg << 1;
                    sh_b_reg <= sh_b_reg >> 1;
                end else begin
                    // Borrow bit set means the trial went negative: restore.
                    sh_a_reg <= {sh_a_reg[WIDTH-2:0], ~div_trial[WIDTH]};
                    acc_reg  <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
                end
            end else begin
                // The top consumes the result on this edge.
                run_reg <= 1'b0;
            end
        end
    end

    assign done   = run_reg && (count_reg == '0);
    assign result = (is_mul_reg || is_rem_reg) ? acc_reg : sh_a_reg;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU. Single-cycle ops retire one cycle after accept;
// MUL/DIVU/REMU (only when ALU_SEQ_MULDIV_EN is defined) take WIDTH+1 cycles.
// Without ALU_SEQ_MULDIV_EN, codes 10-12 report res_err like other unsupported codes.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             res_zero,
    output logic             res_err
);

    alu_state_t       state_reg;
    alu_state_t       state_next;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             res_err_reg;
    logic             res_err_next;

    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic [SHW-1:0]   shamt;

`ifdef ALU_SEQ_MULDIV_EN
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    alu_seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op_sel (op),
        .a      (src_a),
        .b      (src_b),
        .done   (md_done),
        .result (md_result)
    );
`endif

    assign shamt = src_b[SHW-1:0];

    // Single-cycle result, evaluated from the live inputs and registered on accept.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op)
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            ALU_SLL:  alu_res = src_a << shamt;
            ALU_SRL:  alu_res = src_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
`ifdef ALU_SEQ_MULDIV_EN
            ALU_MUL, ALU_DIVU, ALU_REMU: alu_res = '0;
`endif
            default:  alu_err = 1'b1;
        endcase
    end

    // Next-state and result-register update.
    always_comb begin
        state_next   = state_reg;
        res_next     = res_reg;
        res_err_next = res_err_reg;
`ifdef ALU_SEQ_MULDIV_EN
        md_start     = 1'b0;
`endif
        case (state_reg)
            ALU_ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (is_iter_op(op)) begin
                        md_start   = 1'b1;
                        state_next = ALU_ST_BUSY;
                    end else begin
                        res_next     = alu_res;
                        res_err_next = alu_err;
                        state_next   = ALU_ST_DONE;
                    end
`else
                    res_next     = alu_res;
                    res_err_next = alu_err;
                    state_next   = ALU_ST_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            ALU_ST_BUSY: begin
                if (md_done) begin
                    res_next     = md_result;
                    res_err_next = 1'b0;
                    state_next   = ALU_ST_DONE;
                end
            end
`endif
            ALU_ST_DONE: begin
                if (out_ready) begin
                    state_next = ALU_ST_IDLE;
                end
            end
            default: state_next = ALU_ST_IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ALU_ST_IDLE;
            res_reg     <= '0;
            res_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            res_reg     <= res_next;
            res_err_reg <= res_err_next;
        end
    end

    assign in_ready  = (state_reg == ALU_ST_IDLE);
    assign out_valid = (state_reg == ALU_ST_DONE);
    assign res       = res_reg;
    assign res_zero  = (res_reg == '0);
    assign res_err   = res_err_reg;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the CPU's combinational ALU.
- Adds SRL/SRA shifts plus iterative MUL/DIVU/REMU.
- Adds valid/ready on both input and output, and zero/error flags.
- Sits between decode/regfile read and writeback; the core stalls on in_ready/out_valid.
- Single-cycle ops return after one cycle; mul/div ops take WIDTH+1 cycles.

Parameters:
WIDTH, 32, operand/result width in bits (power of two, 8..64)
SHW, $clog2(WIDTH), derived shift-amount width; not to be overridden

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept; high only in IDLE
op  in  4  operation code (ALU_* constants)
src_a  in  WIDTH  operand A
src_b  in  WIDTH  operand B
out_valid  out  1  result available
out_ready  in  1  consumer takes result
res  out  WIDTH  result
res_zero  out  1  res == 0
res_err  out  1  unsupported op code

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, res=0, res_zero=1, res_err=0, iteration counter=0.
- Rst has priority over everything, including mid-iteration and DONE; the in-flight op is discarded and no result is emitted.
- Accept: in_valid && in_ready at an edge latches op, src_a and src_b. Inputs are don't-care afterwards.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE on accepting a single-cycle op; res is computed and registered on that same edge.
  - IDLE -> BUSY on accepting MUL/DIVU/REMU; counter loads WIDTH.
  - BUSY: one iteration per cycle, counter decrements. When counter reaches 0: register res, go to DONE.
  - DONE: out_valid=1; res, res_zero and res_err stable. out_ready=1 -> IDLE at that edge.
- No bypass: accept and retire never overlap, so throughput is at most one op per 2 cycles. in_ready=0 in BUSY and DONE.
- Latency from accept edge to out_valid: 1 cycle for single-cycle ops, WIDTH+1 cycles for iterative ops.
- Op codes:
  - 0 ADD, 1 SUB: mod 2^WIDTH, carry discarded.
  - 2 XOR, 3 OR, 4 AND.
  - 5 SLT (signed), 6 SLTU: result 1 or 0, zero-extended.
  - 7 SLL, 8 SRL, 9 SRA: shift amount = src_b[SHW-1:0], upper bits ignored.
  - 10 MUL: low WIDTH bits of the unsigned product, shift-add.
  - 11 DIVU, 12 REMU: restoring division.
  - 13-15: res=0, res_err=1, single-cycle.
- Divide by zero: DIVU -> all ones; REMU -> src_a; res_err=0.
- res_err=0 for all supported ops.

Optional Feature:
Macro: ALU_SEQ_MULDIV_EN.
- Defined: MUL/DIVU/REMU behave as above, with the BUSY state, counter and datapath present.
- Undefined: codes 10-12 are treated like 13-15 (single-cycle, res=0, res_err=1). BUSY and the iteration logic are not synthesised; the FSM has only IDLE and DONE.

Decomposition:
- Shared header alu.mac.vh holds:
  - ALU_* op-code defines, extended to 4 bits with ALU_SRL, ALU_SRA, ALU_MUL, ALU_DIVU, ALU_REMU.
  - FSM state encodings ALU_ST_IDLE/BUSY/DONE.
- Natural sub-module: alu_seq_muldiv.
  - Holds the iterative multiply/divide datapath (acc, shift regs, counter).
  - Signals: start, done, op_sel, a, b, result.
  - Instantiated only under ALU_SEQ_MULDIV_EN.

Test Plan:
1. Reset, then ADD 0xFFFFFFFF+0x00000002 with out_ready=1 -> out_valid 1 cycle after accept, res=0x00000001, res_zero=0; in_ready high again the cycle after retire.
2. SRA src_a=0x80000000 src_b=0x00000024 -> res=0xF8000000 (amount 4); SRL same operands -> 0x08000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0.
3. DIVU 100/7 -> out_valid exactly 33 cycles after accept, res=14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; in_ready=0 throughout.
4. MUL 0x00010001*0x00010001 -> res=0x00020001; hold out_ready=0 for 5 cycles -> res and out_valid stable, in_valid ignored; release -> retire.
5. Assert rst at BUSY iteration 10 of a DIVU -> next cycle IDLE, in_ready=1, out_valid=0, and no result ever emitted; then SUB 3-3 -> res=0, res_zero=1.
6. op=14 -> res=0, res_err=1 after 1 cycle. With ALU_SEQ_MULDIV_EN undefined, op=10 -> res=0, res_err=1 after 1 cycle.
